// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit 7-segment scan controller.
package display_pkg;

    typedef enum logic [1:0] {
        BLANK_U = 2'd0,
        UNI     = 2'd1,
        BLANK_D = 2'd2,
        DEC     = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}; anything above 9 renders dark.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'b1000000;
            4'd1:    seg_enc = 7'b1111001;
            4'd2:    seg_enc = 7'b0100100;
            4'd3:    seg_enc = 7'b0110000;
            4'd4:    seg_enc = 7'b0011001;
            4'd5:    seg_enc = 7'b0010010;
            4'd6:    seg_enc = 7'b0000010;
            4'd7:    seg_enc = 7'b1111000;
            4'd8:    seg_enc = 7'b0000000;
            4'd9:    seg_enc = 7'b0010000;
            default: seg_enc = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/display_refresh_ctrl_bcd_to_7seg.sv
// Combinational BCD digit to active-low segment pattern.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = seg_enc(i_digit);

endmodule

// File: rtl/display_refresh_ctrl.sv
// Two-digit multiplexed 7-segment driver with blanking gaps between digits.
module display_refresh_ctrl
    import display_pkg::*;
#(
    parameter int ON_CYC    = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] value,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       en_decena,
    output logic       frame_start
);

    localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CW      = $clog2(MAX_CYC);

    scan_state_t   r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_lim_m1;
    logic          w_done;
    logic          w_wrap;
    logic [3:0]    r_pending_q, r_shown_q;
    logic          r_frame_start;
    logic [3:0]    w_units;
    logic          w_tens;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg_digit;

    assign w_lim_m1 = (r_state == UNI || r_state == DEC) ? CW'(ON_CYC - 1) : CW'(BLANK_CYC - 1);
    assign w_done   = (r_cnt == w_lim_m1);
    assign w_wrap   = (r_state == DEC) && w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BLANK_U;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_done ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_done) begin
            case (r_state)
                BLANK_U: w_next = UNI;
                UNI:     w_next = BLANK_D;
                BLANK_D: w_next = DEC;
                default: w_next = BLANK_U;
            endcase
        end
    end

    // shown_q only moves at frame boundaries; a load on that same edge bypasses pending_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending_q   <= '0;
            r_shown_q     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (load)
                r_pending_q <= value;
            if (w_wrap)
                r_shown_q <= load ? value : r_pending_q;
            r_frame_start <= w_wrap;
        end
    end

    assign w_tens  = (r_shown_q >= 4'd10);
    assign w_units = w_tens ? r_shown_q - 4'd10 : r_shown_q;
    assign w_digit = (r_state == DEC) ? {3'b000, w_tens} : w_units;

    bcd_to_7seg u_enc (
        .i_digit (w_digit),
        .o_seg   (w_seg_digit)
    );

    always_comb begin
        seg       = SEG_BLANK;
        an        = AN_OFF;
        en_decena = 1'b0;
        case (r_state)
            UNI: begin
                an  = 4'b1110;
                seg = w_seg_digit;
            end
            DEC: begin
                en_decena = 1'b1;
                if (w_tens) begin
                    an  = 4'b1101;
                    seg = w_seg_digit;
                end
            end
            default: ;
        endcase
    end

    assign frame_start = r_frame_start;

endmodule

// File: doc/display_refresh_ctrl.md
# display_refresh_ctrl

Time-multiplexed two-digit 7-segment driver for the Gray decoder's 4-bit binary result (0–15).
- Splits the value into units and tens and scans them onto a shared active-low segment bus with active-low anodes.
- Inserts a blanking gap between digits to suppress ghosting.
- Drives the digit-select line consumed by the segment-path mux.
- Sits between the Gray-to-binary decoder and the board's display pins.

## Interface
- ON_CYC, default 100000: cycles each digit is lit; must be ≥ 2.
- BLANK_CYC, default 1000: cycles of all-anodes-off between digits; must be ≥ 1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- load  in  1  strobe; samples `value` on the rising edge where it is high.
- value  in  4  binary value 0–15 to display.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  4  active-low anodes:
  - an[0]: units digit.
  - an[1]: tens digit.
  - an[3:2]: constant 1.
- en_decena  out  1  high while the tens digit is selected (DEC state).
- frame_start  out  1  one-cycle pulse on the first cycle of each BLANK_U.

## Operation
- FSM states: BLANK_U → UNI → BLANK_D → DEC → BLANK_U.
- Phase counter `cnt`:
  - Width $clog2(max(ON_CYC, BLANK_CYC)).
  - Cleared on every state change.
  - Advances the state when cnt == limit−1.
  - limit is ON_CYC in UNI/DEC and BLANK_CYC in the blank states.
- Two value registers:
  - `pending_q`: written with `value` on any cycle with load=1. The last load wins.
  - `shown_q`: copied from `pending_q` on the edge that enters BLANK_U, so a frame never mixes two values.
  - Bypass: if load=1 on that same entry edge, `shown_q` takes `value` directly.
- Digit split from `shown_q`:
  - units = shown_q ≥ 10 ? shown_q−10 : shown_q
  - tens = shown_q ≥ 10 ? 1 : 0
- Outputs, all decoded from `state` and `shown_q` flops:
  - BLANK_U / BLANK_D: an=4'b1111, seg=7'b1111111, en_decena=0.
  - UNI: an=4'b1110, seg=enc(units), en_decena=0.
  - DEC, tens=1: an=4'b1101, seg=enc(1), en_decena=1.
  - DEC, tens=0: an=4'b1111, seg=7'b1111111, en_decena=1 (leading-zero blanking).
- Encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 never reach the encoder; the encoder maps them to 7'b1111111.

## Timing
- Reset, asynchronous, while rst_n=0:
  - state=BLANK_U, cnt=0, pending_q=0, shown_q=0.
  - an=4'b1111, seg=7'b1111111, en_decena=0, frame_start=0.
- First frame after rst_n deasserts:
  - BLANK_U spans cycles 0..BLANK_CYC−1.
  - UNI follows for ON_CYC cycles, then BLANK_D, then DEC.
  - Frame period = 2·(ON_CYC+BLANK_CYC) cycles.
  - frame_start is not pulsed for the reset-entered BLANK_U; it pulses on every later entry.
- Latency from load to display:
  - The value appears at the next UNI.
  - Worst case is one full frame plus BLANK_CYC.
- No digit is ever lit in the cycle it changes:
  - Anodes are off for ≥ BLANK_CYC cycles around every digit switch.
  - seg changes only in blank states, or together with the anode in the same registered cycle.
- A reset asserted mid-frame forces all outputs to their reset values immediately; any pending load is discarded.

## Structure
- Package `display_pkg`:
  - state enum `scan_state_t` {BLANK_U, UNI, BLANK_D, DEC}
  - constants SEG_BLANK=7'b1111111, AN_OFF=4'b1111
  - function/array of digit encodings 0–9
- Sub-module `bcd_to_7seg` (4-bit in, 7-bit active-low out): combinational, instantiated once on the selected digit.
- Top-level contents: FSM, counter, value registers and output decode.

## Test plan
All scenarios use ON_CYC=4, BLANK_CYC=2, giving a 12-cycle frame.
- Reset: hold rst_n=0 → an=1111, seg=1111111, en_decena=0. Release → 2 blank cycles, then an=1110, seg=1000000 (shows "0"), tens blank.
- Load value=13 → next frame:
  - UNI: an=1110, seg=0110000 ("3").
  - DEC: an=1101, seg=1111001 ("1"), en_decena=1.
  - Blank states: anodes 1111.
- Load value=7 during DEC of a frame showing 13 → current frame stays 13. The next frame shows UNI "7" (1111000), with DEC anodes 1111 but en_decena=1.
- Loads of 5, then 9, then 12 within one frame → next frame shows 12 (UNI 0100100, DEC "1"). Load asserted on the BLANK_U entry edge with value=10 → that frame shows 10.
- Assert rst_n=0 in the middle of UNI showing 15 → outputs return to reset values the same cycle with no clock edge. After release, the display shows "0".
- frame_start: over three frames, pulses exactly once per frame, 12 cycles apart, aligned to BLANK_U entry. No pulse in the first post-reset frame.
